// File: rtl/mem_responder.sv
// Word-access memory responder with fixed read/write wait states, big-endian, bounds-checked.
// Latency: READ_LAT / WRITE_LAT cycles from acceptance to the one-cycle ready pulse.
// Backpressure: one request outstanding; req while busy is dropped, never queued.
module mem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int READ_LAT    = 3,
  parameter int WRITE_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  RD_LOAD  = 4'(READ_LAT - 1);
  localparam logic [3:0]  WR_LOAD  = 4'(WRITE_LAT - 1);
  localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           enter_done;
  logic [31:0]    addr_q, wdata_q;
  logic           wr_q;
  logic           err_q;
  logic [7:0]     mem [DEPTH_BYTES];

  // The access that completes on the edge entering DONE: with a one-cycle
  // latency that edge is also the acceptance edge, so the live ports are used.
  logic           acc_wr;
  logic [31:0]    acc_addr, acc_wdata;
  logic           acc_bad;
  logic [AW-1:0]  acc_idx;

  // Select live or latched request and check alignment/range on it.
  always_comb begin
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_wr    = wr;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
    acc_bad = (acc_addr[1:0] != 2'b00) || (acc_addr > MAX_ADDR);
    acc_idx = acc_addr[AW-1:0];
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt = wr ? WR_LOAD : RD_LOAD;
          if (cnt_nxt == 4'd0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt_nxt == 4'd0) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latch, read data and error flag; reset aborts any request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr;
      end
      if (enter_done) begin
        err_q <= acc_bad;
        if (!acc_wr) begin
          rdata <= acc_bad ? 32'd0
                           : {mem[acc_idx], mem[acc_idx + AW'(1)],
                              mem[acc_idx + AW'(2)], mem[acc_idx + AW'(3)]};
        end
      end
    end
  end

  // Storage commit, MSB to the lowest address; contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_done && acc_wr && !acc_bad && !reset) begin
      mem[acc_idx]          <= acc_wdata[31:24];
      mem[acc_idx + AW'(1)] <= acc_wdata[23:16];
      mem[acc_idx + AW'(2)] <= acc_wdata[15:8];
      mem[acc_idx + AW'(3)] <= acc_wdata[7:0];
    end
  end

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);
  assign err   = ready & err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a default-latency instance plus a WRITE_LAT=3
// instance sharing the request bus, the second with its own reset for the abort case.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata2;
  logic        ready, busy, err, ready2, busy2, err2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_BYTES(256), .READ_LAT(3), .WRITE_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err));

  mem_responder #(.DEPTH_BYTES(256), .READ_LAT(3), .WRITE_LAT(3)) dut2 (
    .clk(clk), .reset(reset2), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for both instances idle, issue one request, count cycles to ready.
  task automatic do_req(input logic sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic e);
    int guard = 0;
    @(negedge clk);
    while ((busy || busy2) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(sel ? ready2 : ready) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = sel ? rdata2 : rdata;
    e  = sel ? err2 : err;
  endtask

  initial begin
    int          lat;
    int          nrdy;
    logic [31:0] rd;
    logic        e;
    logic [31:0] exp_rd;

    reset = 1'b1; reset2 = 1'b1;
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0; reset2 = 1'b0;

    // Write then read back, big-endian byte order.
    do_req(1'b0, 1'b1, 32'h10, 32'h12345678, lat, rd, e);
    chk("wr10_lat", lat, 32'd1);
    chk("wr10_err", {31'd0, e}, 32'd0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e);
    chk("rd10_lat",   lat, 32'd3);
    chk("rd10_rdata", rd, 32'h12345678);
    chk("rd10_err",   {31'd0, e}, 32'd0);
    chk("peek10", {24'd0, dut.mem[16]}, 32'h12);
    chk("peek13", {24'd0, dut.mem[19]}, 32'h78);

    // Misaligned read.
    do_req(1'b0, 1'b0, 32'h12, 32'h0, lat, rd, e);
    chk("mis_lat",   lat, 32'd3);
    chk("mis_err",   {31'd0, e}, 32'd1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_peek",  {24'd0, dut.mem[18]}, 32'h56);

    // Range: last word valid, one past it rejected without wrap.
    do_req(1'b0, 1'b1, 32'h0, 32'hA5A55A5A, lat, rd, e);
    do_req(1'b0, 1'b1, 32'hFC, 32'h01020304, lat, rd, e);
    chk("top_err", {31'd0, e}, 32'd0);
    do_req(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, lat, rd, e);
    chk("oor_lat", lat, 32'd1);
    chk("oor_err", {31'd0, e}, 32'd1);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, e);
    chk("oor_rd0", rd, 32'hA5A55A5A);
    do_req(1'b0, 1'b0, 32'hFC, 32'h0, lat, rd, e);
    chk("top_rd", rd, 32'h01020304);

    // Request during WAIT is dropped.
    do_req(1'b0, 1'b1, 32'h14, 32'h0A0B0C0D, lat, rd, e);
    @(negedge clk);
    while (busy || busy2) @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    @(posedge clk);
    #1 req = 1'b0;
    nrdy = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (ready) begin
        nrdy++;
        chk("ign_cycle", i, 32'd3);
        chk("ign_rdata", rdata, 32'h12345678);
      end
    end
    chk("ign_count", nrdy, 32'd1);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e);
    chk("ign_after", rd, 32'h12345678);

    // Reset mid-write aborts the commit on the WRITE_LAT=3 instance.
    do_req(1'b1, 1'b1, 32'h20, 32'h11223344, lat, rd, e);
    chk("w3_lat", lat, 32'd3);
    @(negedge clk);
    while (busy || busy2) @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_pre", {31'd0, busy2}, 32'd1);
    #1 reset2 = 1'b1;
    #1;
    chk("abort_busy",  {31'd0, busy2},  32'd0);
    chk("abort_ready", {31'd0, ready2}, 32'd0);
    chk("abort_err",   {31'd0, err2},   32'd0);
    repeat (3) @(negedge clk);
    chk("abort_ready_hold", {31'd0, ready2}, 32'd0);
    reset2 = 1'b0;
    do_req(1'b1, 1'b0, 32'h20, 32'h0, lat, rd, e);
    chk("abort_rd20", rd, 32'h11223344);

    // Held req, alternating addresses: one request every READ_LAT+1 cycles.
    @(negedge clk);
    while (busy || busy2) @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    exp_rd = 32'h12345678;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("held_ready%0d", i), {31'd0, ready}, {31'd0, (i % 4) == 3});
      chk($sformatf("held_busy%0d", i),  {31'd0, busy},  {31'd0, (i % 4) != 0});
      if (ready) begin
        chk($sformatf("held_rdata%0d", i), rdata, exp_rd);
        addr   = (addr == 32'h10) ? 32'h14 : 32'h10;
        exp_rd = (addr == 32'h10) ? 32'h12345678 : 32'h0A0B0C0D;
      end
    end
    req = 1'b0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
